// File: rtl/packer_write_arbiter_pkg.sv
// Shared helpers for the packer write arbiter: log2, derived widths and FSM encoding.
package packer_write_arbiter_pkg;

    // Ceiling log2; c_log_2(1) == 0.
    function automatic int c_log_2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Requester id width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (c_log_2(n) < 1) ? 1 : c_log_2(n);
    endfunction

    // Beats per packed word; same formula the data_packer uses for OUT_NUM_DATA.
    function automatic int pack_beats(input int in_w, input int out_w);
        return (out_w < in_w) ? 1 : (out_w + in_w - 1) / in_w;
    endfunction

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_PAD   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/packer_write_arbiter_if.sv
// Requester-side and packer-side handshake bundle of the packer write arbiter.
interface packer_write_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int IN_WIDTH = 64,
    parameter int ID_W     = packer_write_arbiter_pkg::id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ*IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        pk_write_req;
    logic                        pk_write_ready;
    logic [IN_WIDTH-1:0]         pk_write_data;
    logic [ID_W-1:0]             pk_tag;
    logic                        pk_tag_valid;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;

    // Arbiter side.
    modport master (
        input  req_valid, req_last, req_data, pk_write_ready,
        output req_ready, pk_write_req, pk_write_data, pk_tag, pk_tag_valid,
               grant_id, busy
    );

    // Requesters plus packer side.
    modport slave (
        output req_valid, req_last, req_data, pk_write_ready,
        input  req_ready, pk_write_req, pk_write_data, pk_tag, pk_tag_valid,
               grant_id, busy
    );
endinterface

// File: rtl/packer_write_arbiter_rr_arbiter_comb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_arbiter_comb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = packer_write_arbiter_pkg::id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/packer_write_arbiter.sv
// Shares one data_packer among NUM_REQ narrow write streams, one packed group per grant.
// The downstream data_packer's reset is expected to be driven as ~resetn.
module packer_write_arbiter
    import packer_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   resetn,
    packer_write_arbiter_if.master bus
);

    localparam int PACK_BEATS = pack_beats(IN_WIDTH, OUT_WIDTH);
    localparam int ID_W       = id_width(NUM_REQ);
    localparam int CNT_W      = c_log_2(PACK_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACK_BEATS - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_e         state;
    arb_state_e         state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [CNT_W-1:0]   beat_cnt;
    logic [ID_W-1:0]    pk_tag;
    logic               pk_tag_valid;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;

    logic               write_req;
    logic [IN_WIDTH-1:0] write_data;
    logic [NUM_REQ-1:0] ready;
    logic               complete;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req      (bus.req_valid),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any_req  (arb_any)
    );

    // A fired beat on the last slot of the group closes it, whether real or padding.
    assign complete = write_req && (beat_cnt == LAST_BEAT);

    // State, grant, beat counter, round-robin pointer and completion tag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_oh     <= '0;
            beat_cnt     <= '0;
            pk_tag       <= '0;
            pk_tag_valid <= 1'b0;
        end else begin
            state        <= state_next;
            pk_tag_valid <= complete;
            if (state == ARB_IDLE) begin
                if (arb_any) begin
                    grant_id <= arb_id;
                    grant_oh <= arb_grant;
                    beat_cnt <= '0;
                end
            end else if (write_req) begin
                if (complete) begin
                    beat_cnt <= '0;
                    rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    pk_tag   <= grant_id;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Next state: arbitrate in IDLE, completion beats last-driven padding.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (arb_any) state_next = ARB_BURST;
            end
            ARB_BURST: begin
                if (complete)                             state_next = ARB_IDLE;
                else if (write_req && bus.req_last[grant_id]) state_next = ARB_PAD;
            end
            ARB_PAD: begin
                if (complete) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Outputs: pass the owner's beats in BURST, zero beats in PAD, nothing in IDLE.
    always_comb begin
        write_req  = 1'b0;
        write_data = '0;
        ready      = '0;
        case (state)
            ARB_BURST: begin
                write_req  = bus.req_valid[grant_id] && bus.pk_write_ready;
                write_data = bus.req_data[grant_id*IN_WIDTH +: IN_WIDTH];
                ready      = grant_oh & {NUM_REQ{bus.pk_write_ready}};
            end
            ARB_PAD: begin
                write_req = bus.pk_write_ready;
            end
            default: ;
        endcase
    end

    assign bus.pk_write_req  = write_req;
    assign bus.pk_write_data = write_data;
    assign bus.req_ready     = ready;
    assign bus.pk_tag        = pk_tag;
    assign bus.pk_tag_valid  = pk_tag_valid;
    assign bus.grant_id      = grant_id;
    assign bus.busy          = (state != ARB_IDLE);

endmodule
